// File: rtl/pump_mem_responder_if.sv
// pump_mem_responder_if: pump request bus (initiator = master, responder = slave)
//   wr_en/wr_addr/wr_data -> wr_done
//   rd_en/rd_addr -> rd_valid/rd_data/rd_done
interface pump_mem_responder_if;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_done;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_done;
    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  wr_done, rd_valid, rd_data, rd_done
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output wr_done, rd_valid, rd_data, rd_done
    );
endinterface

// File: rtl/pump_mem_responder.sv
// pump_mem_responder: fixed-latency target for pump requests, decoding to a FlashMem SRAM or pump registers
//   clk, rstn                 clock, async active-low reset
//   bus                       pump request bus (slave side)
//   cfg_wr_en/sel/wr_data     host write port into the 4 pump registers
//   FlashMem_id, pump_addr, pump_size, pump_controller   register contents
//   err_cnt                   saturating count of decode errors and dropped requests
module pump_mem_responder #(
    parameter logic [31:0] FLASHMEM_BASE_ADDR = 32'hA000_0000,
    parameter logic [31:0] PUMP_BASE_ADDR     = 32'hA001_0000,
    parameter int unsigned MEM_AW             = 12,
    parameter int unsigned WR_LATENCY         = 2,
    parameter int unsigned RD_LATENCY         = 3,
    parameter logic [31:0] ERR_DATA           = 32'hDEAD_BEEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    pump_mem_responder_if.slave    bus,
    input  logic                   cfg_wr_en,
    input  logic [1:0]             cfg_sel,
    input  logic [31:0]            cfg_wr_data,
    output logic [31:0]            FlashMem_id,
    output logic [31:0]            pump_addr,
    output logic [31:0]            pump_size,
    output logic [31:0]            pump_controller,
    output logic [15:0]            err_cnt
);
    typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;

    localparam logic [31:0] MEM_BYTES = 32'(4 * (2 ** MEM_AW));

    function automatic logic mem_hit(input logic [31:0] a);
        return (a - FLASHMEM_BASE_ADDR) < MEM_BYTES;
    endfunction

    function automatic logic reg_hit(input logic [31:0] a);
        return a >= PUMP_BASE_ADDR && a < PUMP_BASE_ADDR + 32'd16;
    endfunction

    function automatic logic dec_err(input logic [31:0] a);
        return a[1:0] != 2'b00 || !(mem_hit(a) || reg_hit(a));
    endfunction

    function automatic logic [MEM_AW-1:0] mem_idx(input logic [31:0] a);
        return MEM_AW'((a - FLASHMEM_BASE_ADDR) >> 2);
    endfunction

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        wr_done_q, wr_done_d;
    logic        rd_done_q, rd_done_d;
    logic [15:0] err_q, err_d;
    logic [31:0] regs_q [4];
    logic [31:0] regs_d [4];
    logic [31:0] mem [2 ** MEM_AW];

    logic        accept_wr, accept_rd, is_rd, expire, mem_we;
    logic [1:0]  drops;
    logic [31:0] eff_addr;
    logic [16:0] sum;

    always_comb begin
        accept_wr = state_q == IDLE && bus.wr_en;
        accept_rd = state_q == IDLE && bus.rd_en && !bus.wr_en;
        // While busy the captured address is decoded; in IDLE the incoming one (only matters for latency 1)
        eff_addr  = state_q != IDLE ? addr_q : bus.wr_en ? bus.wr_addr : bus.rd_addr;
        is_rd     = state_q == RD_WAIT || accept_rd;
        expire    = state_q != IDLE ? cnt_q == 16'd1
                  : (accept_wr && WR_LATENCY == 1) || (accept_rd && RD_LATENCY == 1);
        drops     = state_q == IDLE ? 2'(bus.wr_en && bus.rd_en) : 2'(bus.wr_en) + 2'(bus.rd_en);
        state_d   = accept_wr && !expire ? WR_WAIT
                  : accept_rd && !expire ? RD_WAIT
                  : expire ? IDLE : state_q;
        cnt_d     = accept_wr ? 16'(WR_LATENCY - 1)
                  : accept_rd ? 16'(RD_LATENCY - 1)
                  : state_q != IDLE ? cnt_q - 16'd1 : cnt_q;
        addr_d    = accept_wr || accept_rd ? eff_addr : addr_q;
        data_d    = accept_wr ? bus.wr_data : data_q;
        wr_done_d = expire && !is_rd;
        rd_done_d = expire && is_rd;
        // Write commits on the edge that ends the wr_done cycle; host write applied last so it wins
        mem_we    = wr_done_q && mem_hit(addr_q) && !dec_err(addr_q);
        regs_d    = regs_q;
        if (wr_done_q && !mem_hit(addr_q) && !dec_err(addr_q))
            regs_d[addr_q[3:2]] = data_q;
        if (cfg_wr_en)
            regs_d[cfg_sel] = cfg_wr_data;
        // Sampling next-state storage makes rd_data equal the value visible in the done cycle
        rd_data_d = !rd_done_d ? rd_data_q
                  : dec_err(eff_addr) ? ERR_DATA
                  : !mem_hit(eff_addr) ? regs_d[eff_addr[3:2]]
                  : mem_we && mem_idx(addr_q) == mem_idx(eff_addr) ? data_q
                  : mem[mem_idx(eff_addr)];
        sum       = 17'(err_q) + 17'(drops) + 17'(expire && dec_err(eff_addr));
        err_d     = sum[16] ? 16'hFFFF : sum[15:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            rd_data_q <= '0;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
            err_q     <= '0;
            regs_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rd_data_q <= rd_data_d;
            wr_done_q <= wr_done_d;
            rd_done_q <= rd_done_d;
            err_q     <= err_d;
            regs_q    <= regs_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_idx(addr_q)] <= data_q;
    end

    assign bus.wr_done      = wr_done_q;
    assign bus.rd_done      = rd_done_q;
    assign bus.rd_valid     = rd_done_q;
    assign bus.rd_data      = rd_data_q;
    assign FlashMem_id      = regs_q[0];
    assign pump_addr        = regs_q[1];
    assign pump_size        = regs_q[2];
    assign pump_controller  = regs_q[3];
    assign err_cnt          = err_q;
endmodule
